instr_prefetch: RTL and testbench

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/instr_prefetch.sv | 137 +++++++++++++
 tb/tb_instr_prefetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - byte-wide instruction prefetch queue with 1..3-byte length decode
//
// Purpose: streams bytes from a one-cycle-latency read port into a small byte
// queue and presents the instruction at the queue head. The instruction length
// comes from the opcode low nibble. A jump flushes the queue and restarts
// fetching at the target address.
//
// Ports:
//   clk_i          clock, all state changes on the rising edge
//   rst_ni         synchronous active-low reset
//   mem_addr_o     fetch pointer, the address of the current read request
//   mem_strobe_o   read request; the byte returns on mem_data_i next cycle
//   mem_data_i     read data, valid the cycle after a strobe
//   jmp_en_i       redirect pulse
//   jmp_addr_i     redirect target
//   instr_valid_o  a complete instruction is at the queue head
//   instr_ready_i  consumer accepts the head instruction
//   instr_len_o    head instruction length, 1..3
//   instr_b1_o     opcode byte
//   instr_b2_o     second byte, 0 when unused
//   instr_b3_o     third byte, 0 when unused
//   instr_pc_o     address of the head opcode
module instr_prefetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_strobe_o,
  input  logic [7:0]        mem_data_i,
  input  logic              jmp_en_i,
  input  logic [ADDR_W-1:0] jmp_addr_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [1:0]        instr_len_o,
  output logic [7:0]        instr_b1_o,
  output logic [7:0]        instr_b2_o,
  output logic [7:0]        instr_b3_o,
  output logic [ADDR_W-1:0] instr_pc_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;  // count must be able to hold DEPTH itself

  logic [7:0]        queue_q [DEPTH];
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] fetch_q, fetch_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic [7:0]    head_b1, head_b2, head_b3;
  logic [1:0]    len;
  logic [CW-1:0] occupancy;
  logic          strobe, push, valid, pop;

  assign head_b1 = queue_q[rd_q];
  assign head_b2 = queue_q[rd_q + PW'(1)];
  assign head_b3 = queue_q[rd_q + PW'(2)];

  always_comb begin
    len = 2'd2;
    if (head_b1[3:1] == 3'b111)
      len = 2'd1;
    else if (head_b1[3:2] == 2'b01 || head_b1[3:0] == 4'hD)
      len = 2'd3;
  end

  // Counting the in-flight byte as occupied guarantees its slot exists when it
  // lands, so the queue cannot overflow.
  assign occupancy = count_q + CW'(inflight_q);
  assign strobe    = rst_ni && !jmp_en_i && (occupancy < CW'(DEPTH));
  assign push      = rst_ni && !jmp_en_i && inflight_q;
  assign valid     = rst_ni && !jmp_en_i && (count_q >= CW'(len));
  assign pop       = valid && instr_ready_i;

  always_comb begin
    fetch_d    = fetch_q;
    pc_d       = pc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    inflight_d = strobe;
    if (jmp_en_i) begin
      // Flush: the returning byte (if any) is dropped because push is low.
      fetch_d = jmp_addr_i;
      pc_d    = jmp_addr_i;
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (strobe) fetch_d = fetch_q + ADDR_W'(1);
      if (push)   wr_d    = wr_q + PW'(1);
      if (pop) begin
        pc_d = pc_q + ADDR_W'(len);
        rd_d = rd_q + PW'(len);
      end
      count_d = count_q + CW'(push) - (pop ? CW'(len) : CW'(0));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_q    <= RESET_PC;
      pc_q       <= RESET_PC;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_q    <= fetch_d;
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  // Storage needs no reset; count alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push) queue_q[wr_q] <= mem_data_i;
  end

  assign mem_addr_o    = fetch_q;
  assign mem_strobe_o  = strobe;
  assign instr_valid_o = valid;
  assign instr_len_o   = len;
  assign instr_b1_o    = head_b1;
  assign instr_b2_o    = (len >= 2'd2) ? head_b2 : 8'h00;
  assign instr_b3_o    = (len == 2'd3) ? head_b3 : 8'h00;
  assign instr_pc_o    = pc_q;

endmodule

// File: tb/tb_instr_prefetch.sv
// tb/tb_instr_prefetch.sv - directed and randomised checks for instr_prefetch
module tb_instr_prefetch;

  typedef struct {
    logic [1:0]  len;
    logic [7:0]  b1, b2, b3;
    logic [15:0] pc;
  } ins_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, strobe_a, jmp_a, valid_a, ready_a;
  logic [15:0] addr_a, jmp_addr_a, pc_a;
  logic [7:0]  mdata_a, b1_a, b2_a, b3_a;
  logic [1:0]  len_a;

  logic        rst_b, strobe_b, jmp_b, valid_b, ready_b;
  logic [7:0]  addr_b, jmp_addr_b, pc_b;
  logic [7:0]  mdata_b, b1_b, b2_b, b3_b;
  logic [1:0]  len_b;

  logic [7:0]  mem [0:65535];
  ins_t        acc[$];
  logic [7:0]  accb_pc[$];
  logic        rnd_en = 1'b0;
  logic [15:0] exp_pc;
  int          n_rnd_acc = 0;
  int          errors = 0;
  int          checks = 0;

  instr_prefetch dut_a (
    .clk_i(clk), .rst_ni(rst_a), .mem_addr_o(addr_a), .mem_strobe_o(strobe_a),
    .mem_data_i(mdata_a), .jmp_en_i(jmp_a), .jmp_addr_i(jmp_addr_a),
    .instr_valid_o(valid_a), .instr_ready_i(ready_a), .instr_len_o(len_a),
    .instr_b1_o(b1_a), .instr_b2_o(b2_a), .instr_b3_o(b3_a), .instr_pc_o(pc_a)
  );

  instr_prefetch #(.ADDR_W(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_b), .mem_addr_o(addr_b), .mem_strobe_o(strobe_b),
    .mem_data_i(mdata_b), .jmp_en_i(jmp_b), .jmp_addr_i(jmp_addr_b),
    .instr_valid_o(valid_b), .instr_ready_i(ready_b), .instr_len_o(len_b),
    .instr_b1_o(b1_b), .instr_b2_o(b2_b), .instr_b3_o(b3_b), .instr_pc_o(pc_b)
  );

  // One-cycle-latency read port.
  always @(posedge clk) begin
    mdata_a <= mem[addr_a];
    mdata_b <= mem[{8'h00, addr_b}];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] dec(input logic [7:0] op);
    if (op[3:1] == 3'b111) return 2'd1;
    if (op[3:2] == 2'b01 || op[3:0] == 4'hD) return 2'd3;
    return 2'd2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake log plus the byte-level reference model for the random phase.
  always @(negedge clk) begin
    logic [1:0] le;
    if (rst_a && valid_a && ready_a) acc.push_back('{len_a, b1_a, b2_a, b3_a, pc_a});
    if (rst_b && valid_b && ready_b) accb_pc.push_back(pc_b);
    if (!rst_a) exp_pc = 16'h0000;
    else if (rnd_en) begin
      check("count_range", 32'(dut_a.count_q <= 3'd4), 32'd1);
      if (jmp_a) exp_pc = jmp_addr_a;
      else if (valid_a && ready_a) begin
        le = dec(mem[exp_pc]);
        n_rnd_acc++;
        check("rnd_len", 32'(len_a), 32'(le));
        check("rnd_pc", 32'(pc_a), 32'(exp_pc));
        check("rnd_b1", 32'(b1_a), 32'(mem[exp_pc]));
        check("rnd_b2", 32'(b2_a), 32'((le >= 2'd2) ? mem[16'(exp_pc + 16'd1)] : 8'h00));
        check("rnd_b3", 32'(b3_a), 32'((le == 2'd3) ? mem[16'(exp_pc + 16'd2)] : 8'h00));
        exp_pc = 16'(exp_pc + 16'(le));
      end
    end
  end

  initial begin
    rst_a = 0; ready_a = 0; jmp_a = 0; jmp_addr_a = 0;
    rst_b = 0; ready_b = 0; jmp_b = 0; jmp_addr_b = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h0E;
    mem[0] = 8'h0F; mem[1] = 8'h1C; mem[2] = 8'h5A;
    mem[3] = 8'h8D; mem[4] = 8'h12; mem[5] = 8'h34;
    repeat (3) tick();

    // Reset state
    check("rst_strobe", 32'(strobe_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_addr", 32'(addr_a), 32'd0);
    check("rst_pc", 32'(pc_a), 32'd0);

    // In-order stream and best-case latency
    acc.delete();
    rst_a = 1; ready_a = 1; #1;
    check("rel_strobe", 32'(strobe_a), 32'd1);
    check("rel_addr", 32'(addr_a), 32'd0);
    tick(); #1;
    check("lat_n1_valid", 32'(valid_a), 32'd0);
    check("lat_n1_addr", 32'(addr_a), 32'd1);
    tick(); #1;
    check("lat_n2_valid", 32'(valid_a), 32'd1);
    check("lat_n2_len", 32'(len_a), 32'd1);
    check("lat_n2_b1", 32'(b1_a), 32'h0F);
    repeat (12) tick();
    check("seq_count", 32'(acc.size() >= 3), 32'd1);
    if (acc.size() >= 3) begin
      check("seq0_len", 32'(acc[0].len), 32'd1);
      check("seq0_b1", 32'(acc[0].b1), 32'h0F);
      check("seq0_b2", 32'(acc[0].b2), 32'h00);
      check("seq0_pc", 32'(acc[0].pc), 32'd0);
      check("seq1_len", 32'(acc[1].len), 32'd2);
      check("seq1_b1", 32'(acc[1].b1), 32'h1C);
      check("seq1_b2", 32'(acc[1].b2), 32'h5A);
      check("seq1_b3", 32'(acc[1].b3), 32'h00);
      check("seq1_pc", 32'(acc[1].pc), 32'd1);
      check("seq2_len", 32'(acc[2].len), 32'd3);
      check("seq2_b1", 32'(acc[2].b1), 32'h8D);
      check("seq2_b2", 32'(acc[2].b2), 32'h12);
      check("seq2_b3", 32'(acc[2].b3), 32'h34);
      check("seq2_pc", 32'(acc[2].pc), 32'd3);
    end

    // Saturation with consumer stalled
    rst_a = 0; ready_a = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    tick(); tick();
    rst_a = 1; #1;
    repeat (4) tick();
    check("sat_n4_strobe", 32'(strobe_a), 32'd0);
    check("sat_n4_addr", 32'(addr_a), 32'd4);
    repeat (6) tick();
    check("sat_count", 32'(dut_a.count_q), 32'd4);
    check("sat_strobe", 32'(strobe_a), 32'd0);
    check("sat_addr", 32'(addr_a), 32'd4);
    check("sat_valid", 32'(valid_a), 32'd1);
    check("sat_pc", 32'(pc_a), 32'd0);
    check("sat_len", 32'(len_a), 32'd2);

    // Jump with 3 bytes queued and one in flight
    rst_a = 0;
    tick(); tick();
    rst_a = 1; #1;
    repeat (4) tick();
    check("jmp_pre_count", 32'(dut_a.count_q), 32'd3);
    check("jmp_pre_inflight", 32'(dut_a.inflight_q), 32'd1);
    jmp_a = 1; jmp_addr_a = 16'h0040; #1;
    check("jmp_valid", 32'(valid_a), 32'd0);
    check("jmp_strobe", 32'(strobe_a), 32'd0);
    tick();
    jmp_a = 0; #1;
    check("jmp_addr", 32'(addr_a), 32'h40);
    check("jmp_count", 32'(dut_a.count_q), 32'd0);
    check("jmp_strobe_next", 32'(strobe_a), 32'd1);
    acc.delete();
    ready_a = 1;
    repeat (6) tick();
    check("jmp_acc", 32'(acc.size() >= 1), 32'd1);
    if (acc.size() >= 1) check("jmp_first_pc", 32'(acc[0].pc), 32'h40);

    // Reset pulse mid-stream with 2 bytes queued
    rst_a = 0; ready_a = 0;
    tick(); tick();
    rst_a = 1; #1;
    repeat (3) tick();
    check("mid_count", 32'(dut_a.count_q), 32'd2);
    rst_a = 0; #1;
    check("mid_rst_strobe", 32'(strobe_a), 32'd0);
    check("mid_rst_valid", 32'(valid_a), 32'd0);
    tick();
    rst_a = 1; #1;
    check("mid_after_valid", 32'(valid_a), 32'd0);
    check("mid_after_count", 32'(dut_a.count_q), 32'd0);
    check("mid_after_addr", 32'(addr_a), 32'd0);

    // 8-bit address wrap on the second instance
    mem[16'h00FE] = 8'h0F; mem[16'h00FF] = 8'h0F; mem[16'h0000] = 8'h0F;
    rst_b = 1; jmp_b = 1; jmp_addr_b = 8'hFE; ready_b = 1; #1;
    check("wrap_jmp_strobe", 32'(strobe_b), 32'd0);
    tick();
    jmp_b = 0; #1;
    check("wrap_addr_fe", 32'(addr_b), 32'hFE);
    tick(); #1;
    check("wrap_addr_ff", 32'(addr_b), 32'hFF);
    tick(); #1;
    check("wrap_addr_00", 32'(addr_b), 32'h00);
    repeat (6) tick();
    check("wrap_acc", 32'(accb_pc.size() >= 3), 32'd1);
    if (accb_pc.size() >= 3) begin
      check("wrap_pc0", 32'(accb_pc[0]), 32'hFE);
      check("wrap_pc1", 32'(accb_pc[1]), 32'hFF);
      check("wrap_pc2", 32'(accb_pc[2]), 32'h00);
    end

    // Random opcodes, stalls and jumps against the reference model
    rst_a = 0; ready_a = 0; jmp_a = 0;
    tick();
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    tick();
    rst_a = 1; rnd_en = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      ready_a    = ($urandom_range(0, 9) < 7);
      jmp_a      = ($urandom_range(0, 15) == 0);
      jmp_addr_a = 16'($urandom);
    end
    tick();
    rnd_en = 0; jmp_a = 0; ready_a = 0;
    tick();
    check("rnd_activity", 32'(n_rnd_acc > 20), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
